// File: rtl/ovc_credit_tracker.sv
// Output-VC credit tracker: owns downstream credits, allocates the OVC
// per packet, registers flits onto the link and frees after drain.
module ovc_credit_tracker #(
  parameter int FLIT_SIZE  = 32,
  parameter int HEADER_LEN = 2,
  parameter logic [HEADER_LEN-1:0] HEAD_FLIT   = 2'b00,
  parameter logic [HEADER_LEN-1:0] BODY_FLIT   = 2'b01,
  parameter logic [HEADER_LEN-1:0] TAIL_FLIT   = 2'b10,
  parameter logic [HEADER_LEN-1:0] SINGLE_FLIT = 2'b11,
  parameter int VC_SIZE    = 8,
  parameter int IVC_ID_W   = 4,
  parameter int CNT_W      = $clog2(VC_SIZE+1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_req,
  input  logic [IVC_ID_W-1:0]  alloc_id,
  output logic                 alloc_gnt,
  output logic [IVC_ID_W-1:0]  owner,
  output logic                 ovc_busy,
  input  logic [FLIT_SIZE-1:0] flit_in,
  input  logic                 valid_in,
  output logic [FLIT_SIZE-1:0] flit_out,
  output logic                 valid_out,
  input  logic                 credit_in,
  output logic                 credit_avail,
  output logic [CNT_W-1:0]     credit_cnt,
  output logic                 err
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(VC_SIZE);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    FREE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [HEADER_LEN-1:0] ftype;
  logic is_last;
  logic accept;
  logic ovf;
  logic drop;

  assign ftype = flit_in[FLIT_SIZE-1 -: HEADER_LEN];

  always_comb begin
    is_last = 1'b0;
    case (ftype)
      TAIL_FLIT, SINGLE_FLIT: is_last = 1'b1;
      HEAD_FLIT, BODY_FLIT:   is_last = 1'b0;
      default:                is_last = 1'b0;
    endcase
  end

  assign accept = valid_in
                & (state_q == BUSY)
                & (cnt_q != '0);
  // Overflow only when nothing is consumed in the same cycle.
  assign ovf  = credit_in & ~accept
              & (cnt_q == FULL);
  assign drop = valid_in & ~accept;

  always_comb begin
    cnt_d = cnt_q;
    unique case (1'b1)
      accept & ~credit_in:
        cnt_d = cnt_q - ONE;
      ~accept & credit_in & ~ovf:
        cnt_d = cnt_q + ONE;
      default:
        cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FREE:
        if (alloc_req) state_d = BUSY;
      BUSY:
        if (accept & is_last)
          state_d = DRAIN;
      DRAIN:
        if (cnt_d == FULL)
          state_d = FREE;
      default:
        state_d = FREE;
    endcase
  end

  assign alloc_gnt    = alloc_req
                      & (state_q == FREE);
  assign ovc_busy     = (state_q != FREE);
  assign credit_avail = (cnt_q != '0)
                      & (state_q == BUSY);
  assign credit_cnt   = cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= FREE;
      cnt_q     <= FULL;
      owner     <= '0;
      flit_out  <= '0;
      valid_out <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      valid_out <= accept;
      err       <= err | drop | ovf;
      if (alloc_gnt) owner <= alloc_id;
      if (accept) flit_out <= flit_in;
    end
  end

endmodule

// File: tb/tb_ovc_credit_tracker.sv
// Bench for ovc_credit_tracker: behavioural credit/ownership model
// compared every cycle, plus directed literal checks.
module tb_ovc_credit_tracker;

  logic        clk;
  logic        rst;
  logic        alloc_req;
  logic [3:0]  alloc_id;
  logic        alloc_gnt;
  logic [3:0]  owner;
  logic        ovc_busy;
  logic [31:0] flit_in;
  logic        valid_in;
  logic [31:0] flit_out;
  logic        valid_out;
  logic        credit_in;
  logic        credit_avail;
  logic [3:0]  credit_cnt;
  logic        err;

  ovc_credit_tracker dut (
    .clk(clk),
    .rst(rst),
    .alloc_req(alloc_req),
    .alloc_id(alloc_id),
    .alloc_gnt(alloc_gnt),
    .owner(owner),
    .ovc_busy(ovc_busy),
    .flit_in(flit_in),
    .valid_in(valid_in),
    .flit_out(flit_out),
    .valid_out(valid_out),
    .credit_in(credit_in),
    .credit_avail(credit_avail),
    .credit_cnt(credit_cnt),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm,
                     input logic [31:0] a,
                     input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h t=%0t",
               nm, a, e, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [1:0] t,
                                     input logic [29:0] p);
    return {t, p};
  endfunction

  // Model: 0=free 1=owned 2=waiting for downstream to empty
  int          m_state;
  int          m_cnt;
  logic [3:0]  m_owner;
  logic [31:0] m_fout;
  logic        m_vout;
  logic        m_err;
  int          nc;
  bit          acc;
  bit          ov;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_state <= 0;
      m_cnt   <= 8;
      m_owner <= '0;
      m_fout  <= '0;
      m_vout  <= 1'b0;
      m_err   <= 1'b0;
    end else begin
      acc = valid_in && m_state == 1 && m_cnt > 0;
      nc  = m_cnt - (acc ? 1 : 0) + (credit_in ? 1 : 0);
      ov  = nc > 8;
      if (ov) nc = 8;
      m_err  <= m_err || ov || (valid_in && !acc);
      m_vout <= acc;
      if (acc) m_fout <= flit_in;
      m_cnt <= nc;
      case (m_state)
        0: if (alloc_req) begin
             m_state <= 1;
             m_owner <= alloc_id;
           end
        1: if (acc && flit_in[31:30] >= 2'd2) m_state <= 2;
        2: if (nc == 8) m_state <= 0;
        default: m_state <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    chk("cmp_gnt", 32'(alloc_gnt),
        32'(alloc_req && m_state == 0));
    chk("cmp_busy", 32'(ovc_busy), 32'(m_state != 0));
    chk("cmp_avail", 32'(credit_avail),
        32'(m_cnt != 0 && m_state == 1));
    chk("cmp_cnt", 32'(credit_cnt), 32'(m_cnt));
    chk("cmp_owner", 32'(owner), 32'(m_owner));
    chk("cmp_vout", 32'(valid_out), 32'(m_vout));
    chk("cmp_fout", flit_out, m_fout);
    chk("cmp_err", 32'(err), 32'(m_err));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_req = 1'b0;
    valid_in  = 1'b0;
    credit_in = 1'b0;
    flit_in   = '0;
  endtask

  task automatic grab(input logic [3:0] id);
    alloc_req = 1'b1;
    alloc_id  = id;
    #1 chk("grant", 32'(alloc_gnt), 32'd1);
    tick();
    alloc_req = 1'b0;
  endtask

  logic [1:0] types [4];

  initial begin
    types = '{2'b00, 2'b01, 2'b01, 2'b10};
    rst = 1'b0;
    alloc_id = '0;
    idle();
    repeat (2) tick();
    chk("rst_cnt", 32'(credit_cnt), 32'd8);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_busy", 32'(ovc_busy), 32'd0);
    chk("rst_vout", 32'(valid_out), 32'd0);
    chk("rst_fout", flit_out, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b1;
    tick();

    grab(4'h5);
    chk("own_id", 32'(owner), 32'd5);
    chk("own_busy", 32'(ovc_busy), 32'd1);
    chk("own_cnt", 32'(credit_cnt), 32'd8);
    chk("own_avail", 32'(credit_avail), 32'd1);

    for (int i = 0; i < 4; i++) begin
      valid_in = 1'b1;
      flit_in  = mk(types[i], 30'(i + 256));
      tick();
      chk("pkt_vout", 32'(valid_out), 32'd1);
      chk("pkt_fout", flit_out, mk(types[i], 30'(i + 256)));
    end
    valid_in = 1'b0;
    chk("pkt_cnt", 32'(credit_cnt), 32'd4);
    chk("drain_busy", 32'(ovc_busy), 32'd1);
    chk("drain_avail", 32'(credit_avail), 32'd0);
    alloc_req = 1'b1;
    alloc_id  = 4'h7;
    #1 chk("drain_gnt", 32'(alloc_gnt), 32'd0);
    tick();
    alloc_req = 1'b0;
    chk("drain_vout", 32'(valid_out), 32'd0);
    chk("drain_owner", 32'(owner), 32'd5);

    for (int i = 0; i < 4; i++) begin
      credit_in = 1'b1;
      tick();
      chk("ret_cnt", 32'(credit_cnt), 32'(5 + i));
      chk("ret_busy", 32'(ovc_busy), 32'(i < 3));
    end
    credit_in = 1'b0;
    grab(4'h3);
    chk("regrant_owner", 32'(owner), 32'd3);

    valid_in = 1'b1;
    flit_in  = mk(2'b01, 30'h2AA);
    repeat (8) tick();
    chk("empty_cnt", 32'(credit_cnt), 32'd0);
    chk("empty_avail", 32'(credit_avail), 32'd0);
    chk("empty_err", 32'(err), 32'd0);
    tick();
    chk("ninth_vout", 32'(valid_out), 32'd0);
    chk("ninth_err", 32'(err), 32'd1);
    valid_in  = 1'b0;
    credit_in = 1'b1;
    tick();
    chk("one_cnt", 32'(credit_cnt), 32'd1);
    valid_in = 1'b1;
    flit_in  = mk(2'b01, 30'h155);
    tick();
    chk("both_cnt", 32'(credit_cnt), 32'd1);
    chk("both_vout", 32'(valid_out), 32'd1);
    credit_in = 1'b0;
    flit_in   = mk(2'b10, 30'h3);
    tick();
    valid_in = 1'b0;
    chk("tail0_cnt", 32'(credit_cnt), 32'd0);
    chk("tail0_busy", 32'(ovc_busy), 32'd1);
    credit_in = 1'b1;
    repeat (8) tick();
    credit_in = 1'b0;
    chk("refill_cnt", 32'(credit_cnt), 32'd8);
    chk("refill_busy", 32'(ovc_busy), 32'd0);

    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("clr_err", 32'(err), 32'd0);
    credit_in = 1'b1;
    tick();
    credit_in = 1'b0;
    chk("ovf_cnt", 32'(credit_cnt), 32'd8);
    chk("ovf_err", 32'(err), 32'd1);

    rst = 1'b0;
    tick();
    rst = 1'b1;
    valid_in = 1'b1;
    flit_in  = mk(2'b00, 30'h77);
    tick();
    valid_in = 1'b0;
    chk("free_vout", 32'(valid_out), 32'd0);
    chk("free_err", 32'(err), 32'd1);

    rst = 1'b0;
    tick();
    rst = 1'b1;
    grab(4'h9);
    valid_in  = 1'b1;
    credit_in = 1'b1;
    flit_in   = mk(2'b11, 30'h5);
    tick();
    idle();
    chk("single_cnt", 32'(credit_cnt), 32'd8);
    chk("single_busy", 32'(ovc_busy), 32'd1);
    chk("single_vout", 32'(valid_out), 32'd1);
    tick();
    chk("single_free", 32'(ovc_busy), 32'd0);

    grab(4'h2);
    valid_in = 1'b1;
    flit_in  = mk(2'b00, 30'h11);
    tick();
    flit_in  = mk(2'b01, 30'h12);
    tick();
    chk("pre_async_vout", 32'(valid_out), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("async_vout", 32'(valid_out), 32'd0);
    chk("async_cnt", 32'(credit_cnt), 32'd8);
    chk("async_busy", 32'(ovc_busy), 32'd0);
    chk("async_err", 32'(err), 32'd0);
    chk("async_owner", 32'(owner), 32'd0);
    idle();
    tick();
    rst = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ovc_credit_tracker.md
Name: ovc_credit_tracker

Overview:
Output-side counterpart of the input VC, one instance per downstream virtual channel on an output port. It owns the credit count for the downstream VC buffer and drives the credit signal C back to the input VCs. It allocates the output VC to one input VC per packet, registers granted flits onto the link and returns the OVC to the free pool only after the downstream buffer has drained.

Parameters:
FLIT_SIZE, 32, flit width in bits.
HEADER_LEN, 2, width of the flit-type field in flit bits [FLIT_SIZE-1 : FLIT_SIZE-HEADER_LEN].
HEAD_FLIT, 2'b00, type code for a head flit.
BODY_FLIT, 2'b01, type code for a body flit.
TAIL_FLIT, 2'b10, type code for a tail flit.
SINGLE_FLIT, 2'b11, type code for a single-flit packet.
VC_SIZE, 8, downstream VC buffer depth and maximum credit count.
IVC_ID_W, 4, width of the requesting input-VC identifier.
CNT_W, $clog2(VC_SIZE+1), width of the credit counter.

Ports:
clk  in  1  clock, all state on rising edge.
rst  in  1  asynchronous, active-low reset (0 = reset asserted).
alloc_req  in  1  an input VC in WAITING_FOR_OVC requests this OVC.
alloc_id  in  IVC_ID_W  identifier of the requesting input VC.
alloc_gnt  out  1  combinational grant.
owner  out  IVC_ID_W  input VC currently holding this OVC.
ovc_busy  out  1  high whenever state != FREE.
flit_in  in  FLIT_SIZE  flit from the switch.
valid_in  in  1  flit_in is valid this cycle.
flit_out  out  FLIT_SIZE  registered flit onto the link.
valid_out  out  1  registered link valid.
credit_in  in  1  one downstream buffer slot freed.
credit_avail  out  1  the C signal to the input VCs.
credit_cnt  out  CNT_W  current credit count.
err  out  1  sticky protocol-error flag.

Behaviour:
- Reset values (async, rst==0): state=FREE, credit_cnt=VC_SIZE, owner=0, flit_out=0, valid_out=0, err=0. Release of reset is synchronous to clk.
- States are FREE, BUSY and DRAIN; ovc_busy = (state != FREE).
- alloc_gnt = alloc_req & (state==FREE).
  - On a grant, owner<=alloc_id and state<=BUSY in the next cycle.
  - Requests in BUSY or DRAIN are ignored.
- A flit is accepted when valid_in & (state==BUSY) & (credit_cnt!=0).
  - Accepted flit: flit_out<=flit_in and valid_out<=1 on the next edge (1-cycle latency).
  - Any other cycle: valid_out<=0 and flit_out holds its value.
- BUSY -> DRAIN when the accepted flit's type is TAIL_FLIT or SINGLE_FLIT.
- DRAIN -> FREE on the edge where the next credit_cnt equals VC_SIZE, i.e. the downstream VC is empty.
  - If credit_cnt is already VC_SIZE when the tail is accepted (VC_SIZE cannot be reached after a decrement), DRAIN lasts at least one cycle.
- Credit arithmetic:
  - cnt_next = cnt - accepted + credit_in.
  - Accepted and credit_in in the same cycle: cnt unchanged.
  - credit_in with cnt==VC_SIZE and no accept: cnt stays at VC_SIZE (saturate) and err<=1.
- credit_avail = (credit_cnt != 0) & (state==BUSY). Combinational.
- Error conditions set err<=1, which stays set until reset:
  - valid_in while state != BUSY: flit dropped.
  - valid_in in BUSY with credit_cnt==0: flit dropped, cnt unchanged.
  - credit overflow, as above.
- A head flit received while BUSY is not checked; input VCs guarantee packet ordering.
- Reset asserted mid-packet: all state returns to reset values immediately and any in-flight valid_out is lost.

Test Plan:
- Reset, then alloc_req=1, alloc_id=4'h5 -> alloc_gnt=1 that cycle; next cycle state=BUSY, owner=5, ovc_busy=1, credit_cnt=8.
- Owned OVC; send a head, 2 bodies and a tail on consecutive cycles, no credit_in -> valid_out high for 4 cycles, each lagging its input by 1; credit_cnt 8->4; state=DRAIN after the tail; alloc_gnt=0 for a new alloc_req.
- From DRAIN with cnt=4, pulse credit_in for 4 cycles -> cnt 5,6,7,8; state=FREE on the edge cnt reaches 8; a new alloc_req is granted.
- BUSY, 8 flits without credits -> cnt=0 and credit_avail=0; a 9th valid_in -> no valid_out and err=1; then valid_in and credit_in in the same cycle with cnt=1 -> cnt stays 1.
- FREE with cnt=8, credit_in=1 -> cnt stays 8 and err=1; valid_in while FREE -> valid_out stays 0.
- Mid-packet, drive rst=0 asynchronously between edges -> valid_out=0, cnt=8, state=FREE and err=0 immediately, without waiting for a clock edge.
